// File: rtl/surf_cout_autotrain.sv
// surf_cout_autotrain: trains one SURF COUT link. It resets the ISERDES,
// sweeps the IDELAY taps while counting bit errors, keeps the widest clean
// eye, loads its centre, then bitslips until the training word is captured.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i
// S_SRST   | ISERDES reset held for 4 cycles, tap cleared
// S_LOAD   | cycle 0: tap presented; cycle 1: idelay_load_o strobe
// S_SETTLE | SETTLE_CYCLES wait after a load or a bitslip
// S_DWELL  | DWELL_CYCLES of bit error observation on the current tap
// S_EVAL   | fold the tap result into the run/best-eye tracking
// S_CENTER | latch the eye, check its width, pick the centre tap
// S_ALIGN  | compare the captured word against TRAIN_SEQUENCE
// S_SLIP   | bitslip_o strobe
// S_DONE   | training succeeded
// S_FAIL   | training failed or aborted (see fail_code_o)
module surf_cout_autotrain #(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int          TAP_MAX        = 31,
    parameter int          SETTLE_CYCLES  = 64,
    parameter int          DWELL_CYCLES   = 256,
    parameter int          MIN_EYE        = 4,
    parameter int          BITSLIP_MAX    = 31
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] cout_data_i,
    input  logic        cout_valid_i,
    input  logic        cout_biterr_i,
    output logic [5:0]  idelay_value_o,
    output logic        idelay_load_o,
    output logic        iserdes_rst_o,
    output logic        bitslip_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [1:0]  fail_code_o,
    output logic [5:0]  eye_start_o,
    output logic [6:0]  eye_width_o,
    output logic [4:0]  bitslip_count_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_SRST, S_LOAD, S_SETTLE, S_DWELL, S_EVAL,
        S_CENTER, S_ALIGN, S_SLIP, S_DONE, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  tap_q, tap_d;
    logic        err_q, err_d;
    logic        align_q, align_d;
    logic [6:0]  run_len_q, run_len_d;
    logic [5:0]  run_start_q, run_start_d;
    logic [6:0]  best_len_q, best_len_d;
    logic [5:0]  best_start_q, best_start_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [5:0]  eye_start_q, eye_start_d;
    logic [6:0]  eye_width_q, eye_width_d;
    logic [4:0]  slip_cnt_q, slip_cnt_d;

    logic [6:0]  run_len_n;
    logic [5:0]  run_start_n;
    logic [5:0]  centre_tap;
    logic        busy;

    // A clean tap extends the current run; the run starts at the first clean tap.
    assign run_len_n   = err_q ? 7'd0 : run_len_q + 7'd1;
    assign run_start_n = (!err_q && run_len_q == 7'd0) ? tap_q : run_start_q;
    assign centre_tap  = best_start_q + best_len_q[6:1];
    assign busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);

    assign idelay_value_o  = tap_q;
    assign busy_o          = busy;
    assign done_o          = (state_q == S_DONE);
    assign fail_o          = (state_q == S_FAIL);
    assign fail_code_o     = fail_code_q;
    assign eye_start_o     = eye_start_q;
    assign eye_width_o     = eye_width_q;
    assign bitslip_count_o = slip_cnt_q;

    // Next-state, datapath updates and strobes; abort suppresses everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tap_d         = tap_q;
        err_d         = err_q;
        align_d       = align_q;
        run_len_d     = run_len_q;
        run_start_d   = run_start_q;
        best_len_d    = best_len_q;
        best_start_d  = best_start_q;
        fail_code_d   = fail_code_q;
        eye_start_d   = eye_start_q;
        eye_width_d   = eye_width_q;
        slip_cnt_d    = slip_cnt_q;
        idelay_load_o = 1'b0;
        iserdes_rst_o = 1'b0;
        bitslip_o     = 1'b0;

        if (abort_i && busy) begin
            fail_code_d = 2'd3;
            cnt_d       = '0;
            state_d     = S_FAIL;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        fail_code_d  = '0;
                        eye_start_d  = '0;
                        eye_width_d  = '0;
                        slip_cnt_d   = '0;
                        run_len_d    = '0;
                        run_start_d  = '0;
                        best_len_d   = '0;
                        best_start_d = '0;
                        align_d      = 1'b0;
                        err_d        = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_SRST;
                    end
                end
                S_SRST: begin
                    iserdes_rst_o = 1'b1;
                    tap_d         = '0;
                    if (cnt_q == 16'd3) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_LOAD: begin
                    // The tap is already on idelay_value_o for a full cycle before the strobe.
                    if (cnt_q == 16'd0) begin
                        cnt_d = 16'd1;
                    end else begin
                        idelay_load_o = 1'b1;
                        cnt_d         = '0;
                        err_d         = 1'b0;
                        state_d       = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = align_q ? S_ALIGN : S_DWELL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_DWELL: begin
                    if (cout_biterr_i) err_d = 1'b1;
                    if (cnt_q == 16'(DWELL_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_EVAL: begin
                    run_len_d   = run_len_n;
                    run_start_d = run_start_n;
                    if (run_len_n > best_len_q) begin
                        best_len_d   = run_len_n;
                        best_start_d = run_start_n;
                    end
                    if (tap_q < 6'(TAP_MAX)) begin
                        tap_d   = tap_q + 6'd1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_CENTER;
                    end
                end
                S_CENTER: begin
                    eye_start_d = best_start_q;
                    eye_width_d = best_len_q;
                    if (best_len_q < 7'(MIN_EYE)) begin
                        fail_code_d = 2'd1;
                        state_d     = S_FAIL;
                    end else begin
                        tap_d   = centre_tap;
                        align_d = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_ALIGN: begin
                    if (cout_valid_i) begin
                        if (cout_data_i == TRAIN_SEQUENCE) begin
                            state_d = S_DONE;
                        end else if (slip_cnt_q < 5'(BITSLIP_MAX)) begin
                            state_d = S_SLIP;
                        end else begin
                            fail_code_d = 2'd2;
                            state_d     = S_FAIL;
                        end
                    end
                end
                S_SLIP: begin
                    bitslip_o  = 1'b1;
                    slip_cnt_d = slip_cnt_q + 5'd1;
                    cnt_d      = '0;
                    state_d    = S_SETTLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            err_q        <= 1'b0;
            align_q      <= 1'b0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            fail_code_q  <= '0;
            eye_start_q  <= '0;
            eye_width_q  <= '0;
            slip_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            err_q        <= err_d;
            align_q      <= align_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            fail_code_q  <= fail_code_d;
            eye_start_q  <= eye_start_d;
            eye_width_q  <= eye_width_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

endmodule
